// File: rtl/timing_measure_ctrl_pkg.sv
// Shared definitions for the latency-measurement controller: default widths
// and the run-sequencer state encoding.
package timing_measure_ctrl_pkg;

    localparam int unsigned RAM_WIDTH_DFLT = 32;
    localparam int unsigned CNT_WIDTH_DFLT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_TRIG  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/timing_edge_timer.sv
// Feedback rising-edge detector plus a saturating cycle timer with
// synchronous load-to-zero and count enable.
module timing_edge_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fb_in,
    input  logic             load,
    input  logic             en,
    output logic             rise,
    output logic [WIDTH-1:0] timer
);

    localparam logic [WIDTH-1:0] TMR_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] TMR_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TMR_MAX  = {WIDTH{1'b1}};

    logic             fb_q;
    logic             fb_d;
    logic [WIDTH-1:0] timer_q;
    logic [WIDTH-1:0] timer_d;

    // Next-state for the delayed feedback level and the timer.
    always_comb begin
        fb_d    = fb_in;
        timer_d = timer_q;
        if (load) begin
            timer_d = TMR_ZERO;
        end else if (en && (timer_q != TMR_MAX)) begin
            timer_d = timer_q + TMR_ONE;
        end else begin
            timer_d = timer_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_q    <= 1'b0;
            timer_q <= TMR_ZERO;
        end else begin
            fb_q    <= fb_d;
            timer_q <= timer_d;
        end
    end

    assign rise  = fb_in & ~fb_q;
    assign timer = timer_q;

endmodule

// File: rtl/timing_measure_ctrl.sv
// Latency-measurement run sequencer: clears the statistics unit, fires
// trigger pulses and reports feedback latency or timeout per sample.
module timing_measure_ctrl
    import timing_measure_ctrl_pkg::*;
#(
    parameter int _RAM_WIDTH = RAM_WIDTH_DFLT,
    parameter int _CNT_WIDTH = CNT_WIDTH_DFLT
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  io_start,
    input  logic                  io_abort,
    input  logic [_CNT_WIDTH-1:0] io_sampleNum,
    input  logic [_RAM_WIDTH-1:0] io_timeout,
    input  logic [_RAM_WIDTH-1:0] io_interval,
    input  logic                  io_fbIn,
    output logic                  io_trigOut,
    output logic                  io_statClr,
    output logic                  io_fbCatchOut,
    output logic [_RAM_WIDTH-1:0] io_timingOut,
    output logic                  io_busy,
    output logic                  io_done,
    output logic [_CNT_WIDTH-1:0] io_sampleCnt,
    output logic [_CNT_WIDTH-1:0] io_timeoutCnt
);

    localparam logic [_RAM_WIDTH-1:0] RAM_ZERO = {_RAM_WIDTH{1'b0}};
    localparam logic [_RAM_WIDTH-1:0] RAM_ONE  = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [_CNT_WIDTH-1:0] CNT_ZERO = {_CNT_WIDTH{1'b0}};
    localparam logic [_CNT_WIDTH-1:0] CNT_ONE  = {{(_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [_CNT_WIDTH-1:0]   num_q, num_d;
    logic [_RAM_WIDTH-1:0]   tmo_q, tmo_d;
    logic [_RAM_WIDTH-1:0]   intv_q, intv_d;
    logic [_RAM_WIDTH-1:0]   gap_q, gap_d;
    logic [_RAM_WIDTH-1:0]   timing_q, timing_d;
    logic [_CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;
    logic [_CNT_WIDTH-1:0]   timeout_cnt_q, timeout_cnt_d;
    logic                    trig_q, trig_d;
    logic                    clr_q, clr_d;
    logic                    catch_q, catch_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    rise_s;
    logic [_RAM_WIDTH-1:0]   timer_s;
    logic                    tmr_load_s;
    logic                    tmr_en_s;
    logic                    abort_s;

    timing_edge_timer #(
        .WIDTH (_RAM_WIDTH)
    ) u_edge_timer (
        .clk   (io_clk),
        .rst   (io_rst),
        .fb_in (io_fbIn),
        .load  (tmr_load_s),
        .en    (tmr_en_s),
        .rise  (rise_s),
        .timer (timer_s)
    );

    // Next-state, counter and output computation for the run sequencer.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        tmo_d         = tmo_q;
        intv_d        = intv_q;
        gap_d         = gap_q;
        timing_d      = timing_q;
        sample_cnt_d  = sample_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        catch_d       = 1'b0;
        abort_s       = io_abort && (state_q != ST_IDLE);

        // Abort freezes every counter and result; only the state moves.
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (io_start) begin
                        state_d       = ST_CLEAR;
                        num_d         = io_sampleNum;
                        tmo_d         = io_timeout;
                        intv_d        = io_interval;
                        sample_cnt_d  = CNT_ZERO;
                        timeout_cnt_d = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (num_q == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // An edge on the timeout cycle still counts as a catch.
                    if (rise_s) begin
                        state_d      = ST_GAP;
                        catch_d      = 1'b1;
                        timing_d     = timer_s;
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                        gap_d        = intv_q;
                    end else if ((tmo_q != RAM_ZERO) && (timer_s == tmo_q)) begin
                        state_d       = ST_GAP;
                        sample_cnt_d  = sample_cnt_q + CNT_ONE;
                        timeout_cnt_d = timeout_cnt_q + CNT_ONE;
                        gap_d         = intv_q;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_GAP: begin
                    // GAP always occupies at least one cycle, so interval 0 and 1 match.
                    if (gap_q > RAM_ONE) begin
                        gap_d = gap_q - RAM_ONE;
                    end else if (sample_cnt_q < num_q) begin
                        state_d = ST_TRIG;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        trig_d     = (state_d == ST_TRIG);
        clr_d      = (state_d == ST_CLEAR);
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        tmr_load_s = (state_d == ST_TRIG);
        tmr_en_s   = (state_q == ST_TRIG) || (state_q == ST_WAIT);
    end

    // Sequencer state, latched configuration and registered outputs.
    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q       <= ST_IDLE;
            num_q         <= CNT_ZERO;
            tmo_q         <= RAM_ZERO;
            intv_q        <= RAM_ZERO;
            gap_q         <= RAM_ZERO;
            timing_q      <= RAM_ZERO;
            sample_cnt_q  <= CNT_ZERO;
            timeout_cnt_q <= CNT_ZERO;
            trig_q        <= 1'b0;
            clr_q         <= 1'b0;
            catch_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            tmo_q         <= tmo_d;
            intv_q        <= intv_d;
            gap_q         <= gap_d;
            timing_q      <= timing_d;
            sample_cnt_q  <= sample_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            trig_q        <= trig_d;
            clr_q         <= clr_d;
            catch_q       <= catch_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign io_trigOut    = trig_q;
    assign io_statClr    = clr_q;
    assign io_fbCatchOut = catch_q;
    assign io_timingOut  = timing_q;
    assign io_busy       = busy_q;
    assign io_done       = done_q;
    assign io_sampleCnt  = sample_cnt_q;
    assign io_timeoutCnt = timeout_cnt_q;

endmodule
